// File: rtl/mini_alu_pkg.sv
// Shared opcode constants and instruction field layout for the mini ALU core.
package mini_alu_pkg;

    localparam int unsigned InstrW = 28;

    localparam int unsigned OpMsb   = 27;
    localparam int unsigned OpLsb   = 24;
    localparam int unsigned DstMsb  = 23;
    localparam int unsigned DstLsb  = 16;
    localparam int unsigned Src1Msb = 15;
    localparam int unsigned Src1Lsb = 8;
    localparam int unsigned Src0Msb = 7;
    localparam int unsigned Src0Lsb = 0;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpLed  = 4'd1;
    localparam logic [3:0] OpSto  = 4'd2;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpSub  = 4'd4;
    localparam logic [3:0] OpShl  = 4'd5;
    localparam logic [3:0] OpSmul = 4'd6;
    localparam logic [3:0] OpBle  = 4'd7;
    localparam logic [3:0] OpJmp  = 4'd8;
    localparam logic [3:0] OpCall = 4'd9;
    localparam logic [3:0] OpRet  = 4'd10;
    localparam logic [3:0] OpLcd  = 4'd11;

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses; push when full and pop when empty are ignored.
module return_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] top
);

    localparam int unsigned PtrW = $clog2(Depth + 1);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [2**IdxW];
    logic [PtrW-1:0]  sp;
    logic [IdxW-1:0]  writeIdx;
    logic [IdxW-1:0]  topIdx;

    assign empty    = (sp == '0);
    assign full     = (sp == PtrW'(Depth));
    assign writeIdx = IdxW'(sp);
    assign topIdx   = IdxW'(sp - 1'b1);
    assign top      = mem[topIdx];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[writeIdx] <= pushData;
            sp            <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage mini ALU core: fetch with synchronous register read, then execute/writeback,
// with a one-entry write bypass, a return stack and an LCD handshake that stalls the pipe.
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_AW      = 8,
    parameter int unsigned IP_W        = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned LED_W       = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [IP_W-1:0]   oIP,
    input  logic [InstrW-1:0] iInstruction,
    output logic [LED_W-1:0]  oLed,
    output logic [7:0]        oLcdData,
    output logic              oLcdValid,
    input  logic              iLcdReady,
    output logic              oStackErr,
    output logic              oIllegal
);

    localparam int unsigned RegDepth = 2**REG_AW;
    localparam logic [DATA_W-1:0] ShiftLimit = DATA_W'(DATA_W);

    logic [IP_W-1:0]   ipQ, exIpQ;
    logic [3:0]        exOpQ;
    logic [7:0]        exDstQ, exF1Q, exF0Q;
    logic [DATA_W-1:0] rd1Q, rd0Q;
    logic [DATA_W-1:0] regs [RegDepth];
    logic [REG_AW-1:0] bypAddrQ;
    logic [DATA_W-1:0] bypDataQ;
    logic              bypValidQ;
    logic [LED_W-1:0]  ledQ;
    logic              stackErrQ;

    logic [DATA_W-1:0] src1, src0, result;
    logic [IP_W-1:0]   target, stackTop;
    logic              writeEn, branch, push, pop, ledEn, lcdValid, illegal;
    logic              stackFull, stackEmpty, advance;

    return_stack #(
        .Depth(STACK_DEPTH),
        .Width(IP_W)
    ) uStack (
        .Clock   (Clock),
        .Reset   (Reset),
        .push    (push),
        .pop     (pop),
        .pushData(exIpQ + 1'b1),
        .full    (stackFull),
        .empty   (stackEmpty),
        .top     (stackTop)
    );

    always_comb begin
        src1 = (bypValidQ && bypAddrQ == REG_AW'(exF1Q)) ? bypDataQ : rd1Q;
        src0 = (bypValidQ && bypAddrQ == REG_AW'(exF0Q)) ? bypDataQ : rd0Q;
    end

    always_comb begin
        result   = '0;
        writeEn  = 1'b0;
        branch   = 1'b0;
        target   = IP_W'(exDstQ);
        push     = 1'b0;
        pop      = 1'b0;
        ledEn    = 1'b0;
        lcdValid = 1'b0;
        illegal  = 1'b0;
        case (exOpQ)
            OpNop: ;
            OpLed: ledEn = 1'b1;
            OpSto: begin
                result  = DATA_W'({exF1Q, exF0Q});
                writeEn = 1'b1;
            end
            OpAdd: begin
                result  = src1 + src0;
                writeEn = 1'b1;
            end
            OpSub: begin
                result  = src1 - src0;
                writeEn = 1'b1;
            end
            OpShl: begin
                result  = (src0 >= ShiftLimit) ? '0 : (src1 << src0);
                writeEn = 1'b1;
            end
            OpSmul: begin
                // Low half of a two's-complement product matches the unsigned one.
                result  = $unsigned($signed(src1) * $signed(src0));
                writeEn = 1'b1;
            end
            OpBle: branch = (src1 <= src0);
            OpJmp: branch = 1'b1;
            OpCall: begin
                branch = 1'b1;
                push   = 1'b1;
            end
            OpRet: begin
                pop = 1'b1;
                if (!stackEmpty) begin
                    branch = 1'b1;
                    target = stackTop;
                end
            end
            OpLcd: lcdValid = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign advance   = !(lcdValid && !iLcdReady);
    assign oIP       = branch ? target : ipQ;
    assign oLed      = ledQ;
    assign oLcdData  = src1[7:0];
    assign oLcdValid = lcdValid;
    assign oStackErr = stackErrQ;
    assign oIllegal  = illegal;

    // Register file: write from execute, read for the instruction being fetched.
    always_ff @(posedge Clock) begin
        if (writeEn && !Reset) begin
            regs[REG_AW'(exDstQ)] <= result;
        end
        if (advance) begin
            rd1Q <= regs[REG_AW'(iInstruction[Src1Msb:Src1Lsb])];
            rd0Q <= regs[REG_AW'(iInstruction[Src0Msb:Src0Lsb])];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ipQ       <= '0;
            exIpQ     <= '0;
            exOpQ     <= OpNop;
            exDstQ    <= '0;
            exF1Q     <= '0;
            exF0Q     <= '0;
            bypAddrQ  <= '0;
            bypDataQ  <= '0;
            bypValidQ <= 1'b0;
            ledQ      <= '0;
            stackErrQ <= 1'b0;
        end else begin
            if (advance) begin
                ipQ       <= oIP + 1'b1;
                exIpQ     <= oIP;
                exOpQ     <= iInstruction[OpMsb:OpLsb];
                exDstQ    <= iInstruction[DstMsb:DstLsb];
                exF1Q     <= iInstruction[Src1Msb:Src1Lsb];
                exF0Q     <= iInstruction[Src0Msb:Src0Lsb];
                bypValidQ <= writeEn;
                if (writeEn) begin
                    bypAddrQ <= REG_AW'(exDstQ);
                    bypDataQ <= result;
                end
                if (ledEn) begin
                    ledQ <= src1[LED_W-1:0];
                end
            end
            if ((push && stackFull) || (pop && stackEmpty)) begin
                stackErrQ <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mini_alu_core.sv
// Directed tests for mini_alu_core: a behavioural ROM feeds fixed programs, and each
// task checks cycle-exact outputs against hand-computed values.
module tb_mini_alu_core;
    import mini_alu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iLcdReady = 1'b0;
    logic [7:0]  oIP;
    logic [27:0] iInstruction;
    logic [7:0]  oLed;
    logic [7:0]  oLcdData;
    logic        oLcdValid;
    logic        oStackErr;
    logic        oIllegal;

    logic [27:0] rom [256];
    int total = 0;
    int passed = 0;
    int xfers = 0;

    mini_alu_core dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .oIP         (oIP),
        .iInstruction(iInstruction),
        .oLed        (oLed),
        .oLcdData    (oLcdData),
        .oLcdValid   (oLcdValid),
        .iLcdReady   (iLcdReady),
        .oStackErr   (oStackErr),
        .oIllegal    (oIllegal)
    );

    assign iInstruction = rom[oIP];
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (!Reset && oLcdValid && iLcdReady) xfers++;
    end

    function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {OpSto, d, imm};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 28'd0;
    endtask

    // Leaves the bench on the falling edge of cycle 0 (fetching address 0).
    task automatic restart();
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic test_reset();
        clearRom();
        restart();
        total++; if (oIP !== 8'd0) $display("FAIL reset_ip: got %0h want 0", oIP); else passed++;
        total++; if (oLed !== 8'd0) $display("FAIL reset_led: got %0h want 0", oLed); else passed++;
        total++; if (oLcdValid !== 1'b0) $display("FAIL reset_lcdvalid: got %b want 0", oLcdValid);
        else passed++;
        total++; if (oStackErr !== 1'b0) $display("FAIL reset_stackerr: got %b want 0", oStackErr);
        else passed++;
        total++; if (oIllegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", oIllegal);
        else passed++;
        step(3);
        total++; if (oIP !== 8'd3) $display("FAIL seq_fetch: got %0h want 3", oIP); else passed++;
    endtask

    task automatic test_bypass_add();
        clearRom();
        rom[0] = sto(8'd1, 16'd5);
        rom[1] = sto(8'd2, 16'd7);
        rom[2] = ins(OpAdd, 8'd3, 8'd2, 8'd1);
        rom[3] = ins(OpLed, 8'd0, 8'd3, 8'd0);
        rom[4] = ins(OpJmp, 8'd4, 8'd0, 8'd0);
        restart();
        step(4);
        total++; if (oLed !== 8'd0) $display("FAIL led_early: got %0h want 0", oLed); else passed++;
        step(1);
        total++; if (oLed !== 8'd12) $display("FAIL bypass_add: got %0h want c", oLed); else passed++;
    endtask

    task automatic test_arith();
        clearRom();
        rom[0]  = sto(8'd1, 16'hFFFF);
        rom[1]  = sto(8'd2, 16'd3);
        rom[2]  = ins(OpSmul, 8'd4, 8'd1, 8'd2);
        rom[3]  = ins(OpLed, 8'd0, 8'd4, 8'd0);
        rom[4]  = sto(8'd5, 16'd16);
        rom[5]  = ins(OpShl, 8'd6, 8'd1, 8'd5);
        rom[6]  = ins(OpLed, 8'd0, 8'd6, 8'd0);
        rom[7]  = ins(OpShl, 8'd7, 8'd2, 8'd2);
        rom[8]  = ins(OpLed, 8'd0, 8'd7, 8'd0);
        rom[9]  = ins(OpSub, 8'd8, 8'd2, 8'd1);
        rom[10] = ins(OpLed, 8'd0, 8'd8, 8'd0);
        rom[11] = ins(OpJmp, 8'd11, 8'd0, 8'd0);
        restart();
        step(5);
        total++; if (oLed !== 8'hFD) $display("FAIL smul_neg: got %0h want fd", oLed); else passed++;
        step(3);
        total++; if (oLed !== 8'h00) $display("FAIL shl_16: got %0h want 0", oLed); else passed++;
        step(2);
        total++; if (oLed !== 8'h18) $display("FAIL shl_3: got %0h want 18", oLed); else passed++;
        step(2);
        total++; if (oLed !== 8'h04) $display("FAIL sub_wrap: got %0h want 4", oLed); else passed++;
    endtask

    task automatic test_nested_call();
        clearRom();
        rom[8'h00] = ins(OpCall, 8'h10, 8'd0, 8'd0);
        rom[8'h10] = ins(OpCall, 8'h20, 8'd0, 8'd0);
        rom[8'h20] = ins(OpRet, 8'd0, 8'd0, 8'd0);
        rom[8'h11] = ins(OpRet, 8'd0, 8'd0, 8'd0);
        rom[8'h01] = sto(8'd1, 16'h005A);
        rom[8'h02] = ins(OpLed, 8'd0, 8'd1, 8'd0);
        rom[8'h03] = ins(OpJmp, 8'h03, 8'd0, 8'd0);
        restart();
        step(1);
        total++; if (oIP !== 8'h10) $display("FAIL call1_ip: got %0h want 10", oIP); else passed++;
        step(1);
        total++; if (oIP !== 8'h20) $display("FAIL call2_ip: got %0h want 20", oIP); else passed++;
        step(1);
        total++; if (oIP !== 8'h11) $display("FAIL ret1_ip: got %0h want 11", oIP); else passed++;
        step(1);
        total++; if (oIP !== 8'h01) $display("FAIL ret2_ip: got %0h want 1", oIP); else passed++;
        step(3);
        total++; if (oStackErr !== 1'b0) $display("FAIL nest_err: got %b want 0", oStackErr);
        else passed++;
        total++; if (oLed !== 8'h5A) $display("FAIL after_ret: got %0h want 5a", oLed); else passed++;
    endtask

    task automatic test_stack_overflow();
        clearRom();
        rom[8'h00] = ins(OpCall, 8'h10, 8'd0, 8'd0);
        rom[8'h10] = ins(OpCall, 8'h20, 8'd0, 8'd0);
        rom[8'h20] = ins(OpCall, 8'h30, 8'd0, 8'd0);
        rom[8'h30] = ins(OpCall, 8'h40, 8'd0, 8'd0);
        rom[8'h40] = ins(OpCall, 8'h50, 8'd0, 8'd0);
        rom[8'h50] = ins(OpRet, 8'd0, 8'd0, 8'd0);
        rom[8'h31] = ins(OpJmp, 8'h31, 8'd0, 8'd0);
        restart();
        step(4);
        total++; if (oIP !== 8'h40) $display("FAIL call4_ip: got %0h want 40", oIP); else passed++;
        total++; if (oStackErr !== 1'b0) $display("FAIL full_err_early: got %b want 0", oStackErr);
        else passed++;
        step(1);
        total++; if (oIP !== 8'h50) $display("FAIL ovf_branch: got %0h want 50", oIP); else passed++;
        step(1);
        total++; if (oStackErr !== 1'b1) $display("FAIL ovf_err: got %b want 1", oStackErr);
        else passed++;
        total++; if (oIP !== 8'h31) $display("FAIL ovf_dropped: got %0h want 31", oIP); else passed++;
        step(2);
        total++; if (oStackErr !== 1'b1) $display("FAIL err_sticky: got %b want 1", oStackErr);
        else passed++;
    endtask

    task automatic test_stack_underflow();
        clearRom();
        rom[0] = ins(OpRet, 8'd0, 8'd0, 8'd0);
        rom[1] = sto(8'd1, 16'h0033);
        rom[2] = ins(OpLed, 8'd0, 8'd1, 8'd0);
        rom[3] = ins(OpJmp, 8'd3, 8'd0, 8'd0);
        restart();
        step(1);
        total++; if (oIP !== 8'd1) $display("FAIL unf_seq: got %0h want 1", oIP); else passed++;
        step(1);
        total++; if (oStackErr !== 1'b1) $display("FAIL unf_err: got %b want 1", oStackErr);
        else passed++;
        step(2);
        total++; if (oLed !== 8'h33) $display("FAIL unf_cont: got %0h want 33", oLed); else passed++;
    endtask

    task automatic test_illegal();
        clearRom();
        rom[0] = sto(8'd1, 16'h0011);
        rom[1] = ins(4'd15, 8'd1, 8'd0, 8'd0);
        rom[2] = ins(OpLed, 8'd0, 8'd1, 8'd0);
        rom[3] = ins(OpJmp, 8'd3, 8'd0, 8'd0);
        restart();
        step(1);
        total++; if (oIllegal !== 1'b0) $display("FAIL ill_pre: got %b want 0", oIllegal); else passed++;
        step(1);
        total++; if (oIllegal !== 1'b1) $display("FAIL ill_pulse: got %b want 1", oIllegal); else passed++;
        step(1);
        total++; if (oIllegal !== 1'b0) $display("FAIL ill_end: got %b want 0", oIllegal); else passed++;
        step(1);
        total++; if (oLed !== 8'h11) $display("FAIL ill_nowrite: got %0h want 11", oLed); else passed++;
    endtask

    task automatic test_lcd_stall();
        int base;
        clearRom();
        rom[0] = sto(8'd1, 16'h0030);
        rom[1] = ins(OpAdd, 8'd5, 8'd1, 8'd1);
        rom[2] = ins(OpLcd, 8'd0, 8'd5, 8'd0);
        rom[3] = ins(OpLed, 8'd0, 8'd1, 8'd0);
        rom[4] = ins(OpJmp, 8'd4, 8'd0, 8'd0);
        iLcdReady = 1'b0;
        restart();
        base = xfers;
        step(3);
        for (int c = 0; c < 3; c++) begin
            total++; if (oLcdValid !== 1'b1 || oLcdData !== 8'h60 || oIP !== 8'd3)
                $display("FAIL lcd_stall%0d: valid=%b data=%0h ip=%0h want 1/60/3",
                         c, oLcdValid, oLcdData, oIP);
            else passed++;
            step(1);
        end
        total++; if (oLcdValid !== 1'b1) $display("FAIL lcd_4th: got %b want 1", oLcdValid);
        else passed++;
        iLcdReady = 1'b1;
        step(1);
        total++; if (oLcdValid !== 1'b0 || oIP !== 8'd4)
            $display("FAIL lcd_release: valid=%b ip=%0h want 0/4", oLcdValid, oIP);
        else passed++;
        step(2);
        total++; if (oLed !== 8'h30) $display("FAIL lcd_resume: got %0h want 30", oLed); else passed++;
        total++; if (xfers - base !== 1) $display("FAIL lcd_xfers: got %0d want 1", xfers - base);
        else passed++;

        clearRom();
        rom[0] = sto(8'd2, 16'h0042);
        rom[1] = ins(OpLcd, 8'd0, 8'd2, 8'd0);
        rom[2] = ins(OpJmp, 8'd2, 8'd0, 8'd0);
        restart();
        base = xfers;
        step(2);
        total++; if (oLcdValid !== 1'b1 || oLcdData !== 8'h42 || oIP !== 8'd2)
            $display("FAIL lcd_nostall: valid=%b data=%0h ip=%0h want 1/42/2",
                     oLcdValid, oLcdData, oIP);
        else passed++;
        step(1);
        total++; if (oLcdValid !== 1'b0 || xfers - base !== 1)
            $display("FAIL lcd_nostall_end: valid=%b xfers=%0d want 0/1", oLcdValid, xfers - base);
        else passed++;
        iLcdReady = 1'b0;
    endtask

    task automatic test_reset_mid_lcd();
        int base;
        clearRom();
        rom[0] = sto(8'd1, 16'h0009);
        rom[1] = ins(OpLed, 8'd0, 8'd1, 8'd0);
        rom[2] = ins(OpLcd, 8'd0, 8'd1, 8'd0);
        rom[3] = ins(OpJmp, 8'd3, 8'd0, 8'd0);
        iLcdReady = 1'b0;
        restart();
        base = xfers;
        step(4);
        total++; if (oLed !== 8'h09 || oLcdValid !== 1'b1)
            $display("FAIL pre_abort: led=%0h valid=%b want 9/1", oLed, oLcdValid);
        else passed++;
        step(1);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        total++; if (oLcdValid !== 1'b0 || oIP !== 8'd0 || oLed !== 8'd0)
            $display("FAIL lcd_abort: valid=%b ip=%0h led=%0h want 0/0/0", oLcdValid, oIP, oLed);
        else passed++;
        total++; if (xfers - base !== 0) $display("FAIL abort_xfers: got %0d want 0", xfers - base);
        else passed++;
    endtask

    task automatic test_ble();
        clearRom();
        rom[8'h00] = sto(8'd1, 16'd5);
        rom[8'h01] = sto(8'd2, 16'd5);
        rom[8'h02] = sto(8'd3, 16'd6);
        rom[8'h03] = ins(OpBle, 8'h20, 8'd1, 8'd2);
        rom[8'h20] = ins(OpBle, 8'h30, 8'd3, 8'd1);
        rom[8'h21] = ins(OpJmp, 8'h21, 8'd0, 8'd0);
        rom[8'h30] = ins(OpJmp, 8'h30, 8'd0, 8'd0);
        restart();
        step(4);
        total++; if (oIP !== 8'h20) $display("FAIL ble_equal: got %0h want 20", oIP); else passed++;
        step(1);
        total++; if (oIP !== 8'h21) $display("FAIL ble_greater: got %0h want 21", oIP); else passed++;
    endtask

    task automatic test_ip_wrap();
        clearRom();
        rom[0] = ins(OpJmp, 8'hFE, 8'd0, 8'd0);
        restart();
        step(2);
        total++; if (oIP !== 8'hFF) $display("FAIL ip_top: got %0h want ff", oIP); else passed++;
        step(1);
        total++; if (oIP !== 8'h00) $display("FAIL ip_wrap: got %0h want 0", oIP); else passed++;
    endtask

    initial begin
        test_reset();
        test_bypass_add();
        test_arith();
        test_nested_call();
        test_stack_overflow();
        test_stack_underflow();
        test_illegal();
        test_lcd_stall();
        test_reset_mid_lcd();
        test_ble();
        test_ip_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
